kmeans_pass_ctrl: RTL and testbench

- Sequences one k-means assignment pass (3 centroids, 5 dimensions) through the fixed-latency distance/compare pipeline.
- Accepts a stream of N points over valid/ready and forwards them to the pipeline inputs.
- Tracks in-flight points with a valid shift register and accumulates per-centroid coordinate sums and member counts from the pipeline outputs.
- Sits between the point source (DMA/memory reader) and the centroid-update logic, which reads the results through a small read port after done.

---
 rtl/kmeans_ctrl_pkg.sv | 16 +
 rtl/kmeans_valid_delay.sv | 30 +++
 rtl/kmeans_pass_ctrl.sv | 160 ++++++++++++++++
 tb/tb_kmeans_pass_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_ctrl_pkg.sv
// Shared types and constants for the k-means pass controller.
package kmeans_ctrl_pkg;

  localparam int NUM_K    = 3;
  localparam int NUM_D    = 5;
  localparam int PIPE_LAT = 7;
  localparam int K_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/kmeans_valid_delay.sv
// In-flight marker for the distance pipeline: DEPTH-deep 1-bit shift register with sync clear.
module kmeans_valid_delay #(
  parameter int DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic in_i,
  output logic tap_o,
  output logic pend_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  assign sr_d = {sr_q[DEPTH-2:0], in_i};

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tap_o  = sr_q[DEPTH-1];
  // Bits that will still be set after this cycle's shift; lets the drain exit line up with the last tap.
  assign pend_o = |sr_q[DEPTH-2:0];

endmodule

// File: rtl/kmeans_pass_ctrl.sv
// Sequences one k-means assignment pass through the fixed-latency pipeline and accumulates results.
// Optional pass_cycles counter is enabled by defining KMEANS_PASS_CYCLE_CNT_EN.
module kmeans_pass_ctrl
  import kmeans_ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PTS_W    = 20,
  parameter int PIPE_LAT = kmeans_ctrl_pkg::PIPE_LAT,
  parameter int SUM_W    = DATA_W + PTS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PTS_W-1:0]  num_points,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  input  logic [DATA_W-1:0] in_data4,
  output logic [DATA_W-1:0] pipe_data0,
  output logic [DATA_W-1:0] pipe_data1,
  output logic [DATA_W-1:0] pipe_data2,
  output logic [DATA_W-1:0] pipe_data3,
  output logic [DATA_W-1:0] pipe_data4,
  input  logic [K_W-1:0]    pipe_sel,
  input  logic [DATA_W-1:0] pipe_out0,
  input  logic [DATA_W-1:0] pipe_out1,
  input  logic [DATA_W-1:0] pipe_out2,
  input  logic [DATA_W-1:0] pipe_out3,
  input  logic [DATA_W-1:0] pipe_out4,
  output logic              busy,
  output logic              done,
  input  logic [K_W-1:0]    rd_k,
  input  logic [2:0]        rd_d,
  output logic [SUM_W-1:0]  rd_sum,
  output logic [PTS_W-1:0]  rd_count
`ifdef KMEANS_PASS_CYCLE_CNT_EN
  ,
  output logic [31:0]       pass_cycles
`endif
);

  state_e            state_q, state_d;
  logic [PTS_W-1:0]  acc_cnt_q;
  logic [PTS_W-1:0]  npts_q;
  logic [SUM_W-1:0]  sum_q [NUM_K][NUM_D];
  logic [PTS_W-1:0]  cnt_q [NUM_K];
  logic [SUM_W-1:0]  rd_sum_q;
  logic [PTS_W-1:0]  rd_count_q;
  logic [DATA_W-1:0] pout [NUM_D];

  logic hs, start_acc, acc_last, vld_tap, vld_pend, acc_en;

  assign pipe_data0 = in_data0;
  assign pipe_data1 = in_data1;
  assign pipe_data2 = in_data2;
  assign pipe_data3 = in_data3;
  assign pipe_data4 = in_data4;

  assign pout[0] = pipe_out0;
  assign pout[1] = pipe_out1;
  assign pout[2] = pipe_out2;
  assign pout[3] = pipe_out3;
  assign pout[4] = pipe_out4;

  assign in_ready  = (state_q == STREAM);
  assign busy      = (state_q == STREAM) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign hs        = in_valid && in_ready;
  assign start_acc = (state_q == IDLE) && start;
  assign acc_last  = (acc_cnt_q == npts_q - PTS_W'(1));
  // Centroid index 3 is never produced by a healthy pipeline; drop such results untouched.
  assign acc_en    = vld_tap && (int'(pipe_sel) < NUM_K);

  kmeans_valid_delay #(.DEPTH(PIPE_LAT)) u_vld (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_acc),
    .in_i   (hs),
    .tap_o  (vld_tap),
    .pend_o (vld_pend)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_points == '0) ? DONE : STREAM;
      STREAM:  if (hs && acc_last) state_d = DRAIN;
      DRAIN:   if (!vld_pend) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      npts_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        acc_cnt_q <= '0;
        npts_q    <= num_points;
      end else if (hs) begin
        acc_cnt_q <= acc_cnt_q + PTS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      for (int k = 0; k < NUM_K; k++) begin
        cnt_q[k] <= '0;
        for (int d = 0; d < NUM_D; d++) sum_q[k][d] <= '0;
      end
    end else if (acc_en) begin
      for (int k = 0; k < NUM_K; k++) begin
        if (int'(pipe_sel) == k) begin
          cnt_q[k] <= cnt_q[k] + PTS_W'(1);
          for (int d = 0; d < NUM_D; d++) sum_q[k][d] <= sum_q[k][d] + SUM_W'(pout[d]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sum_q   <= '0;
      rd_count_q <= '0;
    end else begin
      rd_sum_q   <= '0;
      rd_count_q <= '0;
      if (int'(rd_k) < NUM_K) begin
        rd_count_q <= cnt_q[rd_k];
        if (int'(rd_d) < NUM_D) rd_sum_q <= sum_q[rd_k][rd_d];
      end
    end
  end

  assign rd_sum   = rd_sum_q;
  assign rd_count = rd_count_q;

`ifdef KMEANS_PASS_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      cyc_q <= '0;
    end else if (busy) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign pass_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_kmeans_pass_ctrl.sv
// Table-driven passes with a pipeline model and a result scoreboard, plus reset-abort sequence.
module tb_kmeans_pass_ctrl;

  localparam int DATA_W   = 16;
  localparam int PTS_W    = 20;
  localparam int PIPE_LAT = 7;
  localparam int SUM_W    = DATA_W + PTS_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PTS_W-1:0]  num_points;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data0, in_data1, in_data2, in_data3, in_data4;
  logic [DATA_W-1:0] pipe_data0, pipe_data1, pipe_data2, pipe_data3, pipe_data4;
  logic [1:0]        pipe_sel;
  logic [DATA_W-1:0] pipe_out0, pipe_out1, pipe_out2, pipe_out3, pipe_out4;
  logic              busy, done;
  logic [1:0]        rd_k;
  logic [2:0]        rd_d;
  logic [SUM_W-1:0]  rd_sum;
  logic [PTS_W-1:0]  rd_count;
`ifdef KMEANS_PASS_CYCLE_CNT_EN
  logic [31:0]       pass_cycles;
`endif

  always #5 clk = ~clk;

  kmeans_pass_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_points(num_points),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
    .in_data3(in_data3), .in_data4(in_data4),
    .pipe_data0(pipe_data0), .pipe_data1(pipe_data1), .pipe_data2(pipe_data2),
    .pipe_data3(pipe_data3), .pipe_data4(pipe_data4),
    .pipe_sel(pipe_sel),
    .pipe_out0(pipe_out0), .pipe_out1(pipe_out1), .pipe_out2(pipe_out2),
    .pipe_out3(pipe_out3), .pipe_out4(pipe_out4),
    .busy(busy), .done(done), .rd_k(rd_k), .rd_d(rd_d),
    .rd_sum(rd_sum), .rd_count(rd_count)
`ifdef KMEANS_PASS_CYCLE_CNT_EN
    , .pass_cycles(pass_cycles)
`endif
  );

  // Pipeline model: fixed PIPE_LAT delay, centroid choice supplied by the bench alongside the data.
  typedef struct packed {
    logic [1:0]             sel;
    logic [4:0][DATA_W-1:0] d;
  } pt_t;

  logic [1:0] cur_sel;
  pt_t        m_pipe [PIPE_LAT];

  always @(posedge clk) begin
    m_pipe[0] <= {cur_sel, pipe_data4, pipe_data3, pipe_data2, pipe_data1, pipe_data0};
    for (int i = 1; i < PIPE_LAT; i++) m_pipe[i] <= m_pipe[i-1];
  end

  assign pipe_sel  = m_pipe[PIPE_LAT-1].sel;
  assign pipe_out0 = m_pipe[PIPE_LAT-1].d[0];
  assign pipe_out1 = m_pipe[PIPE_LAT-1].d[1];
  assign pipe_out2 = m_pipe[PIPE_LAT-1].d[2];
  assign pipe_out3 = m_pipe[PIPE_LAT-1].d[3];
  assign pipe_out4 = m_pipe[PIPE_LAT-1].d[4];

  typedef struct packed {
    logic [PTS_W-1:0]  n;
    logic              gap;
    logic              noise;
    logic [2:0]        slen;
    logic [7:0]        sels;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] dstep;
    logic [DATA_W-1:0] istep;
    logic [PTS_W-1:0]  c0;
    logic [PTS_W-1:0]  c1;
    logic [PTS_W-1:0]  c2;
  } pass_t;

  typedef struct packed {
    logic [2:0][4:0][SUM_W-1:0] sum;
  } exp_t;

  pass_t tbl [6];
  exp_t  sb [$];

  int n_chk = 0;
  int n_err = 0;
  int done_cnt, rdy_cnt, busy_cnt;
  logic last_done, last_busy, hs_prev;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    last_done = done;
    last_busy = busy;
    hs_prev   = in_valid && in_ready;
    done_cnt += int'(done);
    rdy_cnt  += int'(in_ready);
    busy_cnt += int'(busy);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] coord(input pass_t e, input int i, input int d);
    return e.base + DATA_W'(d) * e.dstep + DATA_W'(i) * e.istep;
  endfunction

  task automatic drive_point(input pass_t e, input int i);
    in_data0 = coord(e, i, 0);
    in_data1 = coord(e, i, 1);
    in_data2 = coord(e, i, 2);
    in_data3 = coord(e, i, 3);
    in_data4 = coord(e, i, 4);
    cur_sel  = e.sels[2*(i % int'(e.slen)) +: 2];
  endtask

  task automatic run_pass(input int id, input pass_t e);
    exp_t ex;
    int   i, g, ph, lat;
    logic [PTS_W-1:0] cexp;
    ex = '0;
    done_cnt = 0; rdy_cnt = 0; busy_cnt = 0;
    start = 1'b1; num_points = e.n; in_valid = 1'b0;
    step();
    start = 1'b0;
    i = 0; g = 0; ph = 0;
    while (i < int'(e.n) && g < 5000) begin
      in_valid = !(e.gap && ph[0]);
      ph++;
      drive_point(e, i);
      if (e.noise && i == 1) begin
        start = 1'b1;
        num_points = 20'd99;
      end
      if (i == 0) chk($sformatf("pass%0d pipe_copy", id), pipe_data3, in_data3);
      step();
      start = 1'b0;
      if (hs_prev) begin
        if (cur_sel != 2'd3)
          for (int d = 0; d < 5; d++) ex.sum[cur_sel][d] += SUM_W'(coord(e, i, d));
        i++;
      end
      g++;
    end
    in_valid = 1'b0;
    cur_sel = 2'd3;
    if (g >= 5000) chk($sformatf("pass%0d accept_timeout", id), 64'(i), 64'(e.n));
    sb.push_back(ex);

    lat = (e.n == 0) ? 1 : 0;
    last_done = 1'b0;
    while (!last_done && lat < 100) begin
      if (e.noise && lat == PIPE_LAT) begin
        start = 1'b1;
        num_points = 20'd9;
      end
      step();
      start = 1'b0;
      lat++;
    end
    chk($sformatf("pass%0d done_latency", id), 64'(lat), (e.n == 0) ? 64'd2 : 64'(PIPE_LAT + 1));
    if (e.noise) begin
      step();
      chk($sformatf("pass%0d start_in_done_ignored", id), 64'(last_busy), 64'd0);
    end
    if (e.n == 0) chk($sformatf("pass%0d ready_never", id), 64'(rdy_cnt), 64'd0);

    if (sb.size() == 0) begin
      chk($sformatf("pass%0d scoreboard_empty", id), 64'd0, 64'd1);
    end else begin
      ex = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
        for (int d = 0; d < 5; d++) begin
          rd_k = 2'(k);
          rd_d = 3'(d);
          step();
          chk($sformatf("pass%0d sum[%0d][%0d]", id, k, d), 64'(rd_sum), 64'(ex.sum[k][d]));
          if (d == 0) begin
            cexp = (k == 0) ? e.c0 : (k == 1) ? e.c1 : e.c2;
            chk($sformatf("pass%0d count[%0d]", id, k), 64'(rd_count), 64'(cexp));
          end
        end
      end
    end
    chk($sformatf("pass%0d done_pulses", id), 64'(done_cnt), 64'd1);
`ifdef KMEANS_PASS_CYCLE_CNT_EN
    chk($sformatf("pass%0d pass_cycles", id), 64'(pass_cycles), 64'(busy_cnt));
`endif
  endtask

  initial begin
    pass_t e;
    rst = 1'b1; start = 1'b0; num_points = '0; in_valid = 1'b0;
    in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0; in_data4 = '0;
    cur_sel = 2'd0; rd_k = 2'd0; rd_d = 3'd0;

    tbl[0] = '{n:20'd4,    gap:1'b0, noise:1'b0, slen:3'd4, sels:8'b01_10_01_00,
               base:16'd1,      dstep:16'd1, istep:16'd0,  c0:20'd1,    c1:20'd2, c2:20'd1};
    tbl[1] = '{n:20'd3,    gap:1'b1, noise:1'b0, slen:3'd1, sels:8'b00_00_00_10,
               base:16'd7,      dstep:16'd3, istep:16'd0,  c0:20'd0,    c1:20'd0, c2:20'd3};
    tbl[2] = '{n:20'd0,    gap:1'b0, noise:1'b0, slen:3'd1, sels:8'b00_00_00_00,
               base:16'd5,      dstep:16'd0, istep:16'd0,  c0:20'd0,    c1:20'd0, c2:20'd0};
    tbl[3] = '{n:20'd5,    gap:1'b0, noise:1'b1, slen:3'd3, sels:8'b00_10_01_00,
               base:16'd20,     dstep:16'd1, istep:16'd5,  c0:20'd2,    c1:20'd2, c2:20'd1};
    tbl[4] = '{n:20'd6,    gap:1'b1, noise:1'b0, slen:3'd4, sels:8'b01_11_10_00,
               base:16'd100,    dstep:16'd7, istep:16'd11, c0:20'd2,    c1:20'd1, c2:20'd2};
    tbl[5] = '{n:20'd1000, gap:1'b0, noise:1'b0, slen:3'd1, sels:8'b00_00_00_00,
               base:16'hFFFF,   dstep:16'd0, istep:16'd0,  c0:20'd1000, c1:20'd0, c2:20'd0};

    step();
    step();
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset rd_sum", 64'(rd_sum), 64'd0);
    chk("reset rd_count", 64'(rd_count), 64'd0);
`ifdef KMEANS_PASS_CYCLE_CNT_EN
    chk("reset pass_cycles", 64'(pass_cycles), 64'd0);
`endif
    rst = 1'b0;
    step();

    for (int t = 0; t < 6; t++) run_pass(t, tbl[t]);

    // Abort mid-pass: three points in flight when reset hits.
    e = tbl[0];
    e.n = 20'd10;
    start = 1'b1; num_points = e.n;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive_point(e, i);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) step();
    chk("abort no_done", 64'(done_cnt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      rd_k = 2'(k);
      rd_d = 3'd0;
      step();
      chk($sformatf("abort count[%0d]", k), 64'(rd_count), 64'd0);
      chk($sformatf("abort sum[%0d][0]", k), 64'(rd_sum), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
